// File: rtl/vc_tag_array_pkg.sv
// Shared types and helpers for the victim-cache tag store.
// Way indices are carried at the maximum width and narrowed by each user.
package vc_tag_array_pkg;

  localparam int VC_LKP_MAX      = 4;
  localparam int VC_WAYS_EXP_MAX = 4;
  localparam int VC_WAYS_MAX     = 2 ** VC_WAYS_EXP_MAX;

  typedef logic [VC_WAYS_EXP_MAX-1:0] vc_way_t;

  // Lowest set bit wins; an all-zero vector returns 0.
  function automatic vc_way_t vc_first_one(input logic [VC_WAYS_MAX-1:0] vec);
    vc_way_t idx;
    idx = '0;
    for (int i = VC_WAYS_MAX - 1; i >= 0; i--) begin
      if (vec[i]) idx = vc_way_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vc_tag_array_if.sv
// Request/result bundle of the victim-cache tag store.
// No flow control: every request is accepted in the cycle it is presented.
interface vc_tag_array_if #(
  parameter int AWT         = 32,
  parameter int WORD_SEL    = 4,
  parameter int TAG_WT_VC   = AWT - WORD_SEL - 2,
  parameter int VC_WAYS_EXP = 2,
  parameter int NUM_LKP     = 2
);
  localparam int VC_WAYS = 2 ** VC_WAYS_EXP;

  logic                           wr_en_i;
  logic [VC_WAYS_EXP-1:0]         wr_way_i;
  logic [TAG_WT_VC-1:0]           wr_tag_i;
  logic                           clear_all_i;
  logic                           clear_line_i;
  logic [VC_WAYS_EXP-1:0]         clear_way_i;
  logic                           touch_en_i;
  logic [VC_WAYS_EXP-1:0]         touch_way_i;
  logic [NUM_LKP-1:0]             lkp_en_i;
  logic [NUM_LKP*TAG_WT_VC-1:0]   lkp_tag_i;
  logic [NUM_LKP-1:0]             hit_o;
  logic [NUM_LKP*VC_WAYS_EXP-1:0] hit_way_o;
  logic [VC_WAYS_EXP-1:0]         alloc_way_o;
  logic                           full_o;
  logic [VC_WAYS-1:0]             valid_o;

  modport master (
    output wr_en_i, wr_way_i, wr_tag_i, clear_all_i, clear_line_i, clear_way_i,
           touch_en_i, touch_way_i, lkp_en_i, lkp_tag_i,
    input  hit_o, hit_way_o, alloc_way_o, full_o, valid_o
  );

  modport slave (
    input  wr_en_i, wr_way_i, wr_tag_i, clear_all_i, clear_line_i, clear_way_i,
           touch_en_i, touch_way_i, lkp_en_i, lkp_tag_i,
    output hit_o, hit_way_o, alloc_way_o, full_o, valid_o
  );
endinterface

// File: rtl/vc_tag_array_lru.sv
// True-LRU age registers for the victim cache; ages form a permutation, 0 = MRU.
module vc_lru_age #(
  parameter int VC_WAYS_EXP = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   upd_en_i,
  input  logic [VC_WAYS_EXP-1:0] upd_way_i,
  output logic [VC_WAYS_EXP-1:0] lru_way_o
);
  localparam int VC_WAYS = 2 ** VC_WAYS_EXP;
  typedef logic [VC_WAYS_EXP-1:0] age_t;

  age_t age_q   [VC_WAYS];
  age_t age_nxt [VC_WAYS];
  age_t upd_age;

  always_comb begin
    upd_age = age_q[upd_way_i];
    for (int i = 0; i < VC_WAYS; i++) begin
      age_nxt[i] = age_q[i];
      if (upd_en_i) begin
        if (age_t'(i) == upd_way_i)  age_nxt[i] = '0;
        else if (age_q[i] < upd_age) age_nxt[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_way_o = '0;
    for (int i = 0; i < VC_WAYS; i++) begin
      if (age_q[i] == '1) lru_way_o = age_t'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < VC_WAYS; i++) age_q[i] <= age_t'(i);
    end else begin
      for (int i = 0; i < VC_WAYS; i++) age_q[i] <= age_nxt[i];
    end
  end

endmodule

// File: rtl/vc_tag_array.sv
// Fully-associative victim-cache tag store with registered lookups and write bypass.
// Optional per-way even parity when VC_TAG_PARITY_EN is defined.
module vc_tag_array
  import vc_tag_array_pkg::*;
#(
  parameter int AWT         = 32,
  parameter int WORD_SEL    = 4,
  parameter int TAG_WT_VC   = AWT - WORD_SEL - 2,
  parameter int VC_WAYS_EXP = 2,
  parameter int NUM_LKP     = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  vc_tag_array_if.slave bus
`ifdef VC_TAG_PARITY_EN
  , output logic        par_err_o
`endif
);
  localparam int VC_WAYS  = 2 ** VC_WAYS_EXP;
  localparam int LKP_PORTS = (NUM_LKP > VC_LKP_MAX) ? VC_LKP_MAX : NUM_LKP;

  typedef logic [TAG_WT_VC-1:0]   tag_t;
  typedef logic [VC_WAYS_EXP-1:0] way_t;

  tag_t                           tag_q   [VC_WAYS];
  tag_t                           tag_nxt [VC_WAYS];
  logic [VC_WAYS-1:0]             valid_q, valid_nxt;
  logic [NUM_LKP-1:0]             hit_d, hit_q;
  logic [NUM_LKP*VC_WAYS_EXP-1:0] hit_way_d, hit_way_q;
  logic                           do_clr_all, do_clr_line, do_wr, do_touch;
  logic [VC_WAYS_MAX-1:0]         free_ext;
  way_t                           lru_way;

  // One state action per cycle; a touch only lands in an otherwise idle cycle.
  assign do_clr_all  = bus.clear_all_i;
  assign do_clr_line = ~bus.clear_all_i & bus.clear_line_i;
  assign do_wr       = ~bus.clear_all_i & ~bus.clear_line_i & bus.wr_en_i;
  assign do_touch    = ~bus.clear_all_i & ~bus.clear_line_i & ~bus.wr_en_i & bus.touch_en_i;

`ifdef VC_TAG_PARITY_EN
  logic [VC_WAYS-1:0] par_q, par_nxt, par_bad, fail_or;
  logic [VC_WAYS-1:0] fail_vec [LKP_PORTS];
  logic [VC_WAYS_MAX-1:0] fail_ext;
  logic               inv_pend_q, par_err_q, do_par_inv;
  way_t               inv_way_q;

  assign do_par_inv = inv_pend_q & ~bus.clear_all_i & ~bus.clear_line_i & ~bus.wr_en_i;
`endif

  always_comb begin
    valid_nxt = valid_q;
    for (int i = 0; i < VC_WAYS; i++) tag_nxt[i] = tag_q[i];
`ifdef VC_TAG_PARITY_EN
    par_nxt = par_q;
`endif
    if (do_clr_all) begin
      valid_nxt = '0;
    end else if (do_clr_line) begin
      valid_nxt[bus.clear_way_i] = 1'b0;
    end else if (do_wr) begin
      valid_nxt[bus.wr_way_i] = 1'b1;
      tag_nxt[bus.wr_way_i]   = bus.wr_tag_i;
`ifdef VC_TAG_PARITY_EN
      par_nxt[bus.wr_way_i]   = ^bus.wr_tag_i;
    end else if (do_par_inv) begin
      valid_nxt[inv_way_q] = 1'b0;
`endif
    end
  end

`ifdef VC_TAG_PARITY_EN
  always_comb begin
    for (int i = 0; i < VC_WAYS; i++) par_bad[i] = par_nxt[i] ^ (^tag_nxt[i]);
  end
`endif

  // Lookups compare against the post-update table, which gives the write bypass.
  for (genvar p = 0; p < LKP_PORTS; p++) begin : g_lkp
    tag_t                   lkp_tag;
    logic [VC_WAYS-1:0]     tag_eq, hit_vec;
    logic [VC_WAYS_MAX-1:0] hit_ext;

    assign lkp_tag = bus.lkp_tag_i[p*TAG_WT_VC +: TAG_WT_VC];

    always_comb begin
      for (int i = 0; i < VC_WAYS; i++) tag_eq[i] = valid_nxt[i] && (tag_nxt[i] == lkp_tag);
    end

`ifdef VC_TAG_PARITY_EN
    assign hit_vec     = tag_eq & ~par_bad;
    assign fail_vec[p] = bus.lkp_en_i[p] ? (tag_eq & par_bad) : '0;
`else
    assign hit_vec = tag_eq;
`endif

    always_comb begin
      hit_ext                = '0;
      hit_ext[VC_WAYS-1:0]   = hit_vec;
    end

    assign hit_d[p] = bus.lkp_en_i[p] & (|hit_vec);
    assign hit_way_d[p*VC_WAYS_EXP +: VC_WAYS_EXP] = hit_d[p] ? way_t'(vc_first_one(hit_ext)) : '0;
  end

`ifdef VC_TAG_PARITY_EN
  always_comb begin
    fail_or = '0;
    for (int p = 0; p < LKP_PORTS; p++) fail_or = fail_or | fail_vec[p];
    fail_ext              = '0;
    fail_ext[VC_WAYS-1:0] = fail_or;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < VC_WAYS; i++) tag_q[i] <= '0;
      valid_q   <= '0;
      hit_q     <= '0;
      hit_way_q <= '0;
`ifdef VC_TAG_PARITY_EN
      par_q      <= '0;
      inv_pend_q <= 1'b0;
      inv_way_q  <= '0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < VC_WAYS; i++) tag_q[i] <= tag_nxt[i];
      valid_q   <= valid_nxt;
      hit_q     <= hit_d;
      hit_way_q <= hit_way_d;
`ifdef VC_TAG_PARITY_EN
      par_q      <= par_nxt;
      inv_pend_q <= |fail_or;
      inv_way_q  <= way_t'(vc_first_one(fail_ext));
      par_err_q  <= |fail_or;
`endif
    end
  end

  vc_lru_age #(.VC_WAYS_EXP(VC_WAYS_EXP)) u_lru (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .upd_en_i  (do_wr | do_touch),
    .upd_way_i (do_wr ? bus.wr_way_i : bus.touch_way_i),
    .lru_way_o (lru_way)
  );

  always_comb begin
    free_ext              = '0;
    free_ext[VC_WAYS-1:0] = ~valid_q;
  end

  assign bus.alloc_way_o = (|free_ext) ? way_t'(vc_first_one(free_ext)) : lru_way;
  assign bus.full_o      = &valid_q;
  assign bus.valid_o     = valid_q;
  assign bus.hit_o       = hit_q;
  assign bus.hit_way_o   = hit_way_q;
`ifdef VC_TAG_PARITY_EN
  assign par_err_o = par_err_q;
`endif

endmodule

// File: tb/tb_vc_tag_array.sv
// Directed bench for vc_tag_array (4 ways, 2 lookup ports, 26-bit tags).
// Parity steps are compiled in with VC_TAG_PARITY_EN.
module tb_vc_tag_array;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
`ifdef VC_TAG_PARITY_EN
  logic par_err;
`endif

  vc_tag_array_if vif ();

  vc_tag_array u_dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (vif.slave)
`ifdef VC_TAG_PARITY_EN
    , .par_err_o (par_err)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic idle();
    vif.wr_en_i      = 1'b0;
    vif.wr_way_i     = '0;
    vif.wr_tag_i     = '0;
    vif.clear_all_i  = 1'b0;
    vif.clear_line_i = 1'b0;
    vif.clear_way_i  = '0;
    vif.touch_en_i   = 1'b0;
    vif.touch_way_i  = '0;
    vif.lkp_en_i     = '0;
    vif.lkp_tag_i    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [1:0] way, input logic [25:0] tag);
    vif.wr_en_i  = 1'b1;
    vif.wr_way_i = way;
    vif.wr_tag_i = tag;
  endtask

  task automatic lkp(input logic [1:0] en, input logic [25:0] t0, input logic [25:0] t1);
    vif.lkp_en_i  = en;
    vif.lkp_tag_i = {t1, t0};
  endtask

  // Scoreboard comparison
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    #3;
    chk("rst_hit",     32'(vif.hit_o),       32'h0);
    chk("rst_hit_way", 32'(vif.hit_way_o),   32'h0);
    chk("rst_valid",   32'(vif.valid_o),     32'h0);
    chk("rst_full",    32'(vif.full_o),      32'h0);
    chk("rst_alloc",   32'(vif.alloc_way_o), 32'h0);
`ifdef VC_TAG_PARITY_EN
    chk("rst_par_err", 32'(par_err),         32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill ways 0..3 with 0x100..0x103; ages end 3,2,1,0
    for (int i = 0; i < 4; i++) begin
      wr(2'(i), 26'(32'h100 + i));
      step();
    end
    chk("fill_valid", 32'(vif.valid_o),     32'hF);
    chk("fill_full",  32'(vif.full_o),      32'h1);
    chk("fill_alloc", 32'(vif.alloc_way_o), 32'h0);

    lkp(2'b10, 26'h0, 26'h102);
    step();
    chk("p1_hit",     32'(vif.hit_o),     32'h2);
    chk("p1_hit_way", 32'(vif.hit_way_o), 32'h8);

    // Write bypass on port 0; port 1 looks for way 1's old tag
    wr(2'd1, 26'hABC);
    lkp(2'b11, 26'hABC, 26'h101);
    step();
    chk("byp_hit",     32'(vif.hit_o),       32'h1);
    chk("byp_hit_way", 32'(vif.hit_way_o),   32'h1);
    chk("byp_alloc",   32'(vif.alloc_way_o), 32'h0);

    vif.clear_line_i = 1'b1;
    vif.clear_way_i  = 2'd2;
    lkp(2'b11, 26'h102, 26'h102);
    step();
    chk("cl_hit",     32'(vif.hit_o),       32'h0);
    chk("cl_hit_way", 32'(vif.hit_way_o),   32'h0);
    chk("cl_valid",   32'(vif.valid_o),     32'hB);
    chk("cl_alloc",   32'(vif.alloc_way_o), 32'h2);
    chk("cl_full",    32'(vif.full_o),      32'h0);

    lkp(2'b01, 26'h100, 26'h100);
    step();
    chk("dis_hit",     32'(vif.hit_o),     32'h1);
    chk("dis_hit_way", 32'(vif.hit_way_o), 32'h0);

    // Ways 2 and 3 both hold 0x103; lowest index wins. Ages become 3,1,0,2.
    wr(2'd2, 26'h103);
    lkp(2'b11, 26'h103, 26'h103);
    step();
    chk("dup_hit",     32'(vif.hit_o),       32'h3);
    chk("dup_hit_way", 32'(vif.hit_way_o),   32'hA);
    chk("dup_alloc",   32'(vif.alloc_way_o), 32'h0);
    chk("dup_full",    32'(vif.full_o),      32'h1);

    vif.clear_all_i = 1'b1;
    step();
    chk("ca_valid", 32'(vif.valid_o), 32'h0);

    // LRU: refill 0..3, touch 0, touch 1
    for (int i = 0; i < 4; i++) begin
      wr(2'(i), 26'(32'h200 + i));
      step();
    end
    chk("lru_fill_alloc", 32'(vif.alloc_way_o), 32'h0);
    vif.touch_en_i  = 1'b1;
    vif.touch_way_i = 2'd0;
    step();
    vif.touch_en_i  = 1'b1;
    vif.touch_way_i = 2'd1;
    step();
    chk("lru_touch_alloc", 32'(vif.alloc_way_o), 32'h2);

    wr(2'd2, 26'h2AA);
    lkp(2'b11, 26'h201, 26'h201);
    step();
    chk("lru_wr_alloc", 32'(vif.alloc_way_o), 32'h3);
    chk("same_hit",     32'(vif.hit_o),       32'h3);
    chk("same_hit_way", 32'(vif.hit_way_o),   32'h5);

    // Write beats touch: ages 2,1,0,3 -> write 3 -> LRU is way 0
    wr(2'd3, 26'h2BB);
    vif.touch_en_i  = 1'b1;
    vif.touch_way_i = 2'd0;
    step();
    chk("wr_over_touch_alloc", 32'(vif.alloc_way_o), 32'h0);

    vif.clear_all_i = 1'b1;
    wr(2'd0, 26'h999);
    vif.touch_en_i  = 1'b1;
    vif.touch_way_i = 2'd1;
    lkp(2'b11, 26'h999, 26'h2BB);
    step();
    chk("cab_hit",   32'(vif.hit_o),       32'h0);
    chk("cab_valid", 32'(vif.valid_o),     32'h0);
    chk("cab_alloc", 32'(vif.alloc_way_o), 32'h0);

    lkp(2'b11, 26'h999, 26'h200);
    step();
    chk("cab_next_hit", 32'(vif.hit_o), 32'h0);

    // Reset in the middle of a live lookup result
    wr(2'd1, 26'h321);
    step();
    lkp(2'b01, 26'h321, 26'h0);
    step();
    chk("pre_rst_hit", 32'(vif.hit_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hit",     32'(vif.hit_o),     32'h0);
    chk("mid_rst_hit_way", 32'(vif.hit_way_o), 32'h0);
    chk("mid_rst_valid",   32'(vif.valid_o),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(2'd3, 26'h321);
    lkp(2'b10, 26'h0, 26'h321);
    step();
    chk("post_rst_hit",     32'(vif.hit_o),     32'h2);
    chk("post_rst_hit_way", 32'(vif.hit_way_o), 32'hC);

`ifdef VC_TAG_PARITY_EN
    u_dut.par_q[3] = ~u_dut.par_q[3];
    lkp(2'b01, 26'h321, 26'h0);
    step();
    chk("par_hit",     32'(vif.hit_o),   32'h0);
    chk("par_err_set", 32'(par_err),     32'h1);
    chk("par_valid1",  32'(vif.valid_o), 32'h8);
    step();
    chk("par_err_clr", 32'(par_err),     32'h0);
    chk("par_valid2",  32'(vif.valid_o), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
